i2s_master_ctrl: RTL and testbench
==================================

I2S_MASTER_CTRL -- requirements
Module: i2s_master_ctrl

Interface
REQ-001 Parameter: DATA_W, 16, bits per channel word (legal 8..32).
REQ-002 Parameter: CLK_DIV, 4, clk cycles per SCK half-period (legal >=1).
REQ-003 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: en  input  1  run request; level-sensitive.
REQ-006 Port: left_data  input  DATA_W  left-channel sample.
REQ-007 Port: right_data  input  DATA_W  right-channel sample.
REQ-008 Port: in_valid  input  1  stereo sample pair valid.
REQ-009 Port: in_ready  output  1  holding register empty; the sample pair is accepted when in_valid and in_ready are both high on a clk edge.
REQ-010 Port: SCK  output  1  I2S bit clock, registered.
REQ-011 Port: WS  output  1  word select; 0 = left, 1 = right; registered.
REQ-012 Port: sd_out  output  1  serial data, MSB first, registered.
REQ-013 Port: busy  output  1  high while in RUN.
REQ-014 Port: underrun  output  1  one-clk pulse when a frame starts with no sample held.

Function
REQ-015 Two states, IDLE and RUN; IDLE->RUN when en=1; RUN->IDLE only at a frame boundary with en=0.
REQ-016 In IDLE, SCK, WS and sd_out are 0, and the divider and bit counter are held at 0; the holding register keeps its contents.
REQ-017 Divider: in RUN, SCK toggles every CLK_DIV clk cycles, so the SCK period is 2*CLK_DIV clk cycles with 50% duty.
REQ-018 The SCK low phase comes first after entering RUN; the first rising edge of SCK occurs CLK_DIV cycles after busy rises.
REQ-019 Bit index b counts 0..2*DATA_W-1 and advances on each SCK falling edge (the clk cycle in which SCK goes 1->0), wrapping from 2*DATA_W-1 to 0.
REQ-020 WS and sd_out update only in the clk cycle in which b is loaded or advanced, so they are stable across every SCK rising edge.
REQ-021 Frame load at b=0 (the IDLE->RUN transition or the wrap), with the holding register full: frame_sr <= {left,right}, and the holding register empties.
REQ-022 Frame load at b=0 with the holding register empty: frame_sr <= 0, and underrun pulses high for exactly that clk cycle.
REQ-023 sd_out = frame_sr MSB; frame_sr shifts left by 1 on each advance of b.
REQ-024 WS = 1 for b in [DATA_W-1, 2*DATA_W-2], else 0. This gives the standard I2S one-bit WS lead: WS changes while the previous word's LSB is on sd_out.
REQ-025 in_ready = NOT hold_full. An accept and a frame-load consume never coincide in one cycle; a consume sets in_ready=1 on the next cycle.
REQ-026 en falling mid-frame: the current frame completes. At the next wrap to b=0 the block enters IDLE without loading and without pulsing underrun.
REQ-027 en rising again in the same cycle as the wrap: the block stays in RUN and loads normally.
REQ-028 A sample accepted in IDLE is transmitted by the first frame after en rises.

Reset
REQ-029 rst asserted sets, immediately: state=IDLE, SCK=0, WS=0, sd_out=0, busy=0, underrun=0, divider=0, b=0, frame_sr=0, hold_full=0 (in_ready=1).
REQ-030 rst mid-frame aborts the frame with no completion. Operation resumes per REQ-018 on the first en=1 after deassertion.

Structure
REQ-031 Package i2s_pkg holds the state enum (IDLE, RUN) and the default DATA_W and CLK_DIV constants.
REQ-032 Sub-module i2s_sck_gen holds the CLK_DIV divider and produces the SCK level plus one-clk sck_rise and sck_fall strobes; it is cleared while not in RUN.

Verification
REQ-033 DATA_W=16, CLK_DIV=4, pair A5A5/3C3C held, then en=1 -> SCK period 8 clk. Bits sampled at 32 SCK rises = 0xA5A53C3C MSB first. WS=1 for b=15..30 only. No underrun.
REQ-034 en=1 with no sample held -> all-zero frame, and underrun high for 1 clk in the busy-rise cycle.
REQ-035 in_valid held high with new pairs for 4 frames -> no underrun; in_ready low except the cycle after each frame load; data contiguous.
REQ-036 en dropped at b=5 -> the frame finishes all 32 bits, then busy=0, SCK=0, WS=0; no underrun.
REQ-037 rst pulsed at b=20 -> all outputs 0 in the same cycle; in_ready=1; restart reproduces REQ-033.
REQ-038 CLK_DIV=1 -> SCK = clk/2; the REQ-033 bit pattern is unchanged.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S master transmitter.
package i2s_pkg;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_CLK_DIV = 4;

   // WS leads the word by one bit: high from the left LSB slot up to the right LSB-1 slot.
   function automatic logic ws_for(input int b, input int data_w);
      return (b >= data_w - 1) && (b <= 2*data_w - 2);
   endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// SCK divider: toggles SCK every CLK_DIV clk cycles while running, with edge strobes.
module i2s_sck_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   output logic sck_o,
   output logic sck_rise_o,
   output logic sck_fall_o
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sck_q, sck_d;
   logic          tick;

   assign tick = run_i && (cnt_q == CW'(CLK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q;
      sck_d = sck_q;
      if (!run_i) begin
         cnt_d = '0;
         sck_d = 1'b0;
      end else if (tick) begin
         cnt_d = '0;
         sck_d = ~sck_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sck_q <= sck_d;
      end
   end

   assign sck_o      = sck_q;
   assign sck_rise_o = tick && !sck_q;
   assign sck_fall_o = tick && sck_q;

endmodule

// File: rtl/i2s_master_ctrl.sv
// I2S master transmitter: one-deep stereo holding register feeding a 2*DATA_W frame shifter.
module i2s_master_ctrl import i2s_pkg::*; #(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] left_data,
   input  logic [DATA_W-1:0] right_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              SCK,
   output logic              WS,
   output logic              sd_out,
   output logic              busy,
   output logic              underrun
);

   localparam int FW = 2 * DATA_W;
   localparam int BW = $clog2(FW);

   state_e         state_q, state_d;
   logic [BW-1:0]  b_q, b_d, b_next;
   logic [FW-1:0]  frame_q, frame_d;
   logic [FW-1:0]  hold_q, hold_d;
   logic           hold_full_q, hold_full_d;
   logic           ws_q, ws_d;
   logic           underrun_q, underrun_d;
   logic           run, sck_rise, sck_fall, load;

   assign run    = (state_q == RUN);
   assign b_next = b_q + 1'b1;

   i2s_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
      .clk_i      (clk),
      .rst_i      (rst),
      .run_i      (run),
      .sck_o      (SCK),
      .sck_rise_o (sck_rise),
      .sck_fall_o (sck_fall)
   );

   always_comb begin
      state_d     = state_q;
      b_d         = b_q;
      frame_d     = frame_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      ws_d        = ws_q;
      underrun_d  = 1'b0;
      load        = 1'b0;

      // Accept only into an empty holder, so it can never collide with a consuming load.
      if (in_valid && !hold_full_q) begin
         hold_d      = {left_data, right_data};
         hold_full_d = 1'b1;
      end

      case (state_q)
         IDLE: if (en) begin
            state_d = RUN;
            load    = 1'b1;
         end
         RUN: if (sck_fall) begin
            if (b_q == BW'(FW - 1)) begin
               if (en) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
                  b_d     = '0;
                  frame_d = '0;
                  ws_d    = 1'b0;
               end
            end else begin
               b_d     = b_next;
               frame_d = frame_q << 1;
               ws_d    = ws_for(int'(b_next), DATA_W);
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         b_d  = '0;
         ws_d = ws_for(0, DATA_W);
         if (hold_full_q) begin
            frame_d     = hold_q;
            hold_full_d = 1'b0;
         end else begin
            frame_d    = '0;
            underrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         b_q         <= '0;
         frame_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         ws_q        <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         b_q         <= b_d;
         frame_q     <= frame_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         ws_q        <= ws_d;
         underrun_q  <= underrun_d;
      end
   end

   // A rising SCK edge outside RUN would mean the divider escaped its clear.
   always_ff @(posedge clk) begin
      if (!rst && sck_rise) assert (run);
   end

   assign in_ready = !hold_full_q;
   assign WS       = ws_q;
   assign sd_out   = frame_q[FW-1];
   assign busy     = run;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_master_ctrl.sv
// Directed bench for i2s_master_ctrl: CLK_DIV=4 instance plus a CLK_DIV=1 instance.
module tb_i2s_master_ctrl;

   localparam int DW = 16;
   localparam logic [31:0] PAT_A   = 32'hA5A5_3C3C;
   localparam logic [31:0] WS_MASK = 32'h0001_FFFE;

   logic          clk = 1'b0;
   logic          rst, en, in_valid, en1, in_valid1;
   logic [DW-1:0] left_data, right_data;
   logic          in_ready, sck, ws, sd, busy, underrun;
   logic          in_ready1, sck1, ws1, sd1, busy1, underrun1;

   always #5 clk = ~clk;

   i2s_master_ctrl #(.DATA_W(DW), .CLK_DIV(4)) dut (
      .clk(clk), .rst(rst), .en(en), .left_data(left_data), .right_data(right_data),
      .in_valid(in_valid), .in_ready(in_ready), .SCK(sck), .WS(ws), .sd_out(sd),
      .busy(busy), .underrun(underrun)
   );

   i2s_master_ctrl #(.DATA_W(DW), .CLK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .en(en1), .left_data(left_data), .right_data(right_data),
      .in_valid(in_valid1), .in_ready(in_ready1), .SCK(sck1), .WS(ws1), .sd_out(sd1),
      .busy(busy1), .underrun(underrun1)
   );

   int          checks = 0, failures = 0;
   bit          feed = 1'b0;
   int          pidx = 0, acc_cnt = 0, rdy_hi = 0;
   logic [31:0] pairs [0:5];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One clk cycle; when feeding, the bench replaces the sample after each accept.
   task automatic step();
      logic acc;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (feed && acc) begin
         acc_cnt++;
         if (pidx < 5) pidx++;
         left_data  = pairs[pidx][31:16];
         right_data = pairs[pidx][15:0];
      end
      if (feed && in_ready) rdy_hi++;
   endtask

   task automatic capture(input string tag, input bit sel, input int drop_at, input int stop_at,
                          output logic [31:0] bits, output logic [31:0] wsb,
                          output int first, output int period, output int urun);
      int   k, cyc;
      logic prev, s;
      k = 0; cyc = 0; bits = '0; wsb = '0; first = -1; period = -1; urun = 0;
      prev = sel ? sck1 : sck;
      while (k < 32 && cyc < 400) begin
         step();
         cyc++;
         s = sel ? sck1 : sck;
         if (sel ? underrun1 : underrun) urun++;
         if (s && !prev) begin
            bits[31-k] = sel ? sd1 : sd;
            wsb[31-k]  = sel ? ws1 : ws;
            if (k == 0) first = cyc;
            if (k == 1) period = cyc - first;
            if (k == drop_at) begin
               if (sel) en1 = 1'b0; else en = 1'b0;
            end
            if (k == stop_at) k = 32; else k++;
         end
         prev = s;
      end
      chk(tag, 64'(k >= 32), 64'd1);
   endtask

   task automatic wait_idle(input string tag, input bit sel, output int n);
      n = 0;
      while ((sel ? busy1 : busy) && n < 40) begin
         step();
         n++;
      end
      chk(tag, 64'(sel ? busy1 : busy), 64'd0);
   endtask

   task automatic preload(input logic [31:0] p, input bit sel);
      left_data  = p[31:16];
      right_data = p[15:0];
      if (sel) in_valid1 = 1'b1; else in_valid = 1'b1;
      step();
      in_valid  = 1'b0;
      in_valid1 = 1'b0;
   endtask

   initial begin
      logic [31:0] bits, wsb;
      int          first, period, urun, n;

      for (int i = 0; i < 6; i++) pairs[i] = {16'hA000 | 16'(i), 16'h0500 | 16'(i * 3)};
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; en1 = 1'b0; in_valid1 = 1'b0;
      left_data = '0; right_data = '0;

      @(posedge clk); #1;
      chk("rst_sck", 64'(sck), 0);
      chk("rst_ws", 64'(ws), 0);
      chk("rst_sd", 64'(sd), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_underrun", 64'(underrun), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      step();
      rst = 1'b0;

      // A: sample held in IDLE, then run; en dropped at b=5 so the frame ends cleanly.
      preload(PAT_A, 1'b0);
      chk("A_hold_full", 64'(in_ready), 0);
      chk("A_idle_busy", 64'(busy), 0);
      en = 1'b1;
      step();
      chk("A_busy_rise", 64'(busy), 1);
      chk("A_first_sd", 64'(sd), 1);
      chk("A_no_urun0", 64'(underrun), 0);
      chk("A_consumed", 64'(in_ready), 1);
      capture("A_cap", 1'b0, 5, -1, bits, wsb, first, period, urun);
      chk("A_bits", 64'(bits), 64'(PAT_A));
      chk("A_ws", 64'(wsb), 64'(WS_MASK));
      chk("A_first_rise", 64'(first), 4);
      chk("A_period", 64'(period), 8);
      chk("A_urun", 64'(urun), 0);
      wait_idle("A_idle", 1'b0, n);
      chk("A_end_lat", 64'(n), 4);
      chk("A_end_sck", 64'(sck), 0);
      chk("A_end_ws", 64'(ws), 0);

      // B: nothing held -> zero frame with a single underrun pulse on the busy-rise cycle.
      en = 1'b1;
      step();
      chk("B_busy", 64'(busy), 1);
      chk("B_urun_pulse", 64'(underrun), 1);
      chk("B_sd", 64'(sd), 0);
      capture("B_cap", 1'b0, 5, -1, bits, wsb, first, period, urun);
      chk("B_bits", 64'(bits), 0);
      chk("B_ws", 64'(wsb), 64'(WS_MASK));
      chk("B_urun_after", 64'(urun), 0);
      wait_idle("B_idle", 1'b0, n);

      // C: continuous feed for four frames.
      feed = 1'b1; pidx = 0;
      left_data = pairs[0][31:16]; right_data = pairs[0][15:0];
      in_valid = 1'b1;
      step();
      acc_cnt = 0; rdy_hi = 0;
      en = 1'b1;
      step();
      chk("C_urun0", 64'(underrun), 0);
      for (int f = 0; f < 4; f++) begin
         capture("C_cap", 1'b0, -1, -1, bits, wsb, first, period, urun);
         chk("C_bits", 64'(bits), 64'(pairs[f]));
         chk("C_urun", 64'(urun), 0);
      end
      chk("C_accepts", 64'(acc_cnt), 4);
      chk("C_ready_cycles", 64'(rdy_hi), 4);
      en = 1'b0; in_valid = 1'b0; feed = 1'b0;
      wait_idle("C_idle", 1'b0, n);
      rst = 1'b1;
      step();
      rst = 1'b0;

      // D: reset at b=20 clears everything immediately; restart reproduces A.
      preload(PAT_A, 1'b0);
      en = 1'b1;
      step();
      capture("D_cap", 1'b0, -1, 20, bits, wsb, first, period, urun);
      chk("D_pre_sck", 64'(sck), 1);
      rst = 1'b1;
      #1;
      chk("D_rst_sck", 64'(sck), 0);
      chk("D_rst_ws", 64'(ws), 0);
      chk("D_rst_sd", 64'(sd), 0);
      chk("D_rst_busy", 64'(busy), 0);
      chk("D_rst_urun", 64'(underrun), 0);
      chk("D_rst_ready", 64'(in_ready), 1);
      step();
      en = 1'b0;
      rst = 1'b0;
      step();
      chk("D_idle_sck", 64'(sck), 0);
      preload(PAT_A, 1'b0);
      en = 1'b1;
      step();
      chk("D_restart_urun", 64'(underrun), 0);
      capture("D_cap2", 1'b0, 5, -1, bits, wsb, first, period, urun);
      chk("D_bits", 64'(bits), 64'(PAT_A));
      chk("D_ws", 64'(wsb), 64'(WS_MASK));
      chk("D_first_rise", 64'(first), 4);
      chk("D_period", 64'(period), 8);
      wait_idle("D_idle", 1'b0, n);

      // E: CLK_DIV=1 -> SCK at clk/2, same bit pattern.
      preload(PAT_A, 1'b1);
      chk("E_hold_full", 64'(in_ready1), 0);
      en1 = 1'b1;
      step();
      chk("E_busy", 64'(busy1), 1);
      chk("E_first_sd", 64'(sd1), 1);
      capture("E_cap", 1'b1, 5, -1, bits, wsb, first, period, urun);
      chk("E_bits", 64'(bits), 64'(PAT_A));
      chk("E_ws", 64'(wsb), 64'(WS_MASK));
      chk("E_first_rise", 64'(first), 1);
      chk("E_period", 64'(period), 2);
      chk("E_urun", 64'(urun), 0);
      wait_idle("E_idle", 1'b1, n);
      chk("E_end_sck", 64'(sck1), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
